// File: rtl/uart_rx_fsm_pkg.sv
// Shared types and helpers for the UART receive frame controller.
package uart_rx_fsm_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    VALID  = 3'd5
  } rx_state_e;

  localparam int unsigned PRESCALE_8  = 8;
  localparam int unsigned PRESCALE_16 = 16;
  localparam int unsigned PRESCALE_32 = 32;

  function automatic int unsigned last_edge(input int unsigned prescale);
    return prescale - 1;
  endfunction

  // Sampled bit settles two edges past mid-bit; unsupported ratios fall back to x8 timing.
  function automatic int unsigned sample_edge(input int unsigned prescale);
    if (prescale inside {PRESCALE_8, PRESCALE_16, PRESCALE_32}) return prescale / 2 + 2;
    return PRESCALE_8 / 2 + 2;
  endfunction

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Control/status bundle between the frame controller and the receive datapath.
interface uart_rx_fsm_if #(
  parameter int PRESCALE_W = 6,
  parameter int CNT_W      = 5
);
  logic                  rx_in;
  logic [PRESCALE_W-1:0] prescale;
  logic                  par_en;
  logic                  strt_glitch;
  logic                  par_err;
  logic                  stp_err;
  logic [CNT_W-1:0]      edge_cnt;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  dat_samp_en;
  logic                  deser_en;
  logic                  strt_chk_en;
  logic                  par_chk_en;
  logic                  stp_chk_en;
  logic                  data_valid;

  modport master (
    input  rx_in, prescale, par_en, strt_glitch, par_err, stp_err,
    output edge_cnt, bit_cnt, dat_samp_en, deser_en,
           strt_chk_en, par_chk_en, stp_chk_en, data_valid
  );

  modport slave (
    output rx_in, prescale, par_en, strt_glitch, par_err, stp_err,
    input  edge_cnt, bit_cnt, dat_samp_en, deser_en,
           strt_chk_en, par_chk_en, stp_chk_en, data_valid
  );
endinterface

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversample edge counter and frame bit counter; edge wraps at prescale-1 and advances bit.
module uart_rx_edge_bit_counter
  import uart_rx_fsm_pkg::*;
#(
  parameter int PRESCALE_W = 6,
  parameter int CNT_W      = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  input  logic                  clear_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic [CNT_W-1:0]      edge_cnt_o,
  output logic [CNT_W-1:0]      bit_cnt_o
);

  logic [CNT_W-1:0] edge_q, edge_d;
  logic [CNT_W-1:0] bit_q, bit_d;
  logic [CNT_W-1:0] last;

  assign last = CNT_W'(last_edge(32'(prescale_i)));

  always_comb begin
    edge_d = edge_q;
    bit_d  = bit_q;
    if (clear_i) begin
      edge_d = '0;
      bit_d  = '0;
    end else if (enable_i) begin
      if (edge_q == last) begin
        edge_d = '0;
        bit_d  = bit_q + 1'b1;
      end else begin
        edge_d = edge_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else begin
      edge_q <= edge_d;
      bit_q  <= bit_d;
    end
  end

  assign edge_cnt_o = edge_q;
  assign bit_cnt_o  = bit_q;

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive frame controller: start detection, bit tracking, checker and deserializer enables.
module uart_rx_fsm
  import uart_rx_fsm_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6,
  parameter int CNT_W      = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  uart_rx_fsm_if.master rx_if
);

  rx_state_e        state_q, state_d;
  logic             par_en_q, par_en_d;
  logic             cnt_en, cnt_clear;
  logic             at_last, in_window;
  logic [CNT_W-1:0] edge_cnt, bit_cnt;
  logic [CNT_W-1:0] last, sp;

  logic dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid;

  assign last      = CNT_W'(last_edge(32'(rx_if.prescale)));
  assign sp        = CNT_W'(sample_edge(32'(rx_if.prescale)));
  assign at_last   = (edge_cnt == last);
  assign in_window = (edge_cnt >= sp);

  uart_rx_edge_bit_counter #(
    .PRESCALE_W (PRESCALE_W),
    .CNT_W      (CNT_W)
  ) u_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable_i   (cnt_en),
    .clear_i    (cnt_clear),
    .prescale_i (rx_if.prescale),
    .edge_cnt_o (edge_cnt),
    .bit_cnt_o  (bit_cnt)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!rx_if.rx_in) state_d = START;
      START:   if (at_last) state_d = rx_if.strt_glitch ? IDLE : DATA;
      DATA:    if (at_last && bit_cnt == CNT_W'(DATA_WIDTH)) state_d = par_en_q ? PARITY : STOP;
      PARITY:  if (at_last) state_d = rx_if.par_err ? IDLE : STOP;
      STOP:    if (at_last) state_d = rx_if.stp_err ? IDLE : VALID;
      VALID:   state_d = rx_if.rx_in ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  // VALID is not a bit position, so the counters restart there; bit_cnt never exceeds 10.
  always_comb begin
    cnt_en    = (state_q != IDLE);
    cnt_clear = (state_d == IDLE) ||
                ((state_d != state_q) && (state_d == START || state_d == VALID));
    par_en_d  = par_en_q;
    if (state_d == START && state_q != START) par_en_d = rx_if.par_en;
  end

  always_comb begin
    dat_samp_en = (state_q != IDLE);
    deser_en    = (state_q == DATA) || (state_q == PARITY) ||
                  (state_q == STOP) || (state_q == VALID);
    strt_chk_en = (state_q == START)  && in_window;
    par_chk_en  = (state_q == PARITY) && in_window;
    stp_chk_en  = (state_q == STOP)   && in_window;
    data_valid  = (state_q == VALID);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      par_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      par_en_q <= par_en_d;
    end
  end

  assign rx_if.edge_cnt    = edge_cnt;
  assign rx_if.bit_cnt     = bit_cnt;
  assign rx_if.dat_samp_en = dat_samp_en;
  assign rx_if.deser_en    = deser_en;
  assign rx_if.strt_chk_en = strt_chk_en;
  assign rx_if.par_chk_en  = par_chk_en;
  assign rx_if.stp_chk_en  = stp_chk_en;
  assign rx_if.data_valid  = data_valid;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: frame-offset reference model compared every cycle, plus directed frame checks.
module tb_uart_rx_fsm;

  localparam int PW = 6;
  localparam int CW = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_fsm_if #(.PRESCALE_W(PW), .CNT_W(CW)) bus ();

  uart_rx_fsm #(.DATA_WIDTH(8), .PRESCALE_W(PW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx_if (bus)
  );

  typedef struct {
    bit samp, deser, strt, par, stp, dv, cnt_ok;
    int edge_n, bit_n;
  } exp_t;

  int  n_checks = 0;
  int  n_errors = 0;
  int  cyc      = 0;
  bit  chk_on   = 0;

  // Reference: a frame is just a cycle offset m_t from its first START cycle.
  bit  m_active = 0;
  int  m_t      = 0;
  bit  m_par    = 0;

  int  tref = 0;
  int  dv_q[$];
  int  ds_first, ds_last;
  int  stp_first, stp_last, stp_n, stp_bit, edge_max;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int flen(input bit par);
    return par ? 11 : 10;
  endfunction

  function automatic exp_t model_out(input bit act, input int t, input bit par, input int P);
    exp_t e;
    int b, ed, sp;
    e = '{default: 0};
    if (act) begin
      e.samp = 1;
      if (t == flen(par) * P) begin
        e.deser = 1;
        e.dv    = 1;
      end else begin
        b  = t / P;
        ed = t % P;
        sp = P / 2 + 2;
        e.deser  = (b >= 1);
        e.strt   = (b == 0) && (ed >= sp);
        e.par    = par && (b == 9) && (ed >= sp);
        e.stp    = (b == flen(par) - 1) && (ed >= sp);
        e.cnt_ok = 1;
        e.edge_n = ed;
        e.bit_n  = b;
      end
    end
    return e;
  endfunction

  function automatic bit aborts(input int b, input bit par);
    return (b == 0 && bus.strt_glitch) || (par && b == 9 && bus.par_err) ||
           (b == flen(par) - 1 && bus.stp_err);
  endfunction

  task automatic reset_stats();
    dv_q.delete();
    ds_first  = -1; ds_last  = -1;
    stp_first = -1; stp_last = -1; stp_n = 0; stp_bit = -1;
    edge_max  = 0;
  endtask

  // One clock: advance the reference from the inputs seen at this edge, then compare.
  task automatic cycle();
    int   P;
    bit   n_act, n_par;
    int   n_t;
    exp_t e;
    P = int'(bus.prescale);
    n_act = m_active; n_t = m_t; n_par = m_par;
    if (!rst_n) n_act = 0;
    else if (!m_active) begin
      if (!bus.rx_in) begin n_act = 1; n_t = 0; n_par = bus.par_en; end
    end else if (m_t == flen(m_par) * P) begin
      if (!bus.rx_in) begin n_t = 0; n_par = bus.par_en; end
      else n_act = 0;
    end else if ((m_t % P == P - 1) && aborts(m_t / P, m_par)) n_act = 0;
    else n_t = m_t + 1;

    @(posedge clk);
    #1;
    cyc++;
    m_active = n_act; m_t = n_t; m_par = n_par;

    if (chk_on) begin
      e = model_out(m_active, m_t, m_par, P);
      check("dat_samp_en", bus.dat_samp_en, e.samp);
      check("deser_en",    bus.deser_en,    e.deser);
      check("strt_chk_en", bus.strt_chk_en, e.strt);
      check("par_chk_en",  bus.par_chk_en,  e.par);
      check("stp_chk_en",  bus.stp_chk_en,  e.stp);
      check("data_valid",  bus.data_valid,  e.dv);
      if (e.cnt_ok) begin
        check("edge_cnt", bus.edge_cnt, e.edge_n);
        check("bit_cnt",  bus.bit_cnt,  e.bit_n);
      end
    end

    if (bus.data_valid === 1'b1) dv_q.push_back(cyc - tref);
    if (bus.deser_en === 1'b1) begin
      if (ds_first < 0) ds_first = cyc - tref;
      ds_last = cyc - tref;
    end
    if (bus.stp_chk_en === 1'b1) begin
      if (stp_first < 0) stp_first = int'(bus.edge_cnt);
      stp_last = int'(bus.edge_cnt);
      stp_bit  = int'(bus.bit_cnt);
      stp_n++;
    end
    if (int'(bus.edge_cnt) > edge_max) edge_max = int'(bus.edge_cnt);
  endtask

  function automatic logic line_bit(input int b, input int c, input int err,
                                    input bit par, input logic [7:0] d);
    if (b == 0) return (err == 1 && c >= 2) ? 1'b1 : 1'b0;
    if (b <= 8) return d[3'(b - 1)];
    if (par && b == 9) return ^d;
    return 1'b1;
  endfunction

  // err: 0 none, 1 start glitch, 2 parity error, 3 stop error (raised at LAST of that bit).
  task automatic drive_frame(input int P, input bit par, input logic [7:0] d, input int err,
                             input int rst_at, input bit chain_in, input bit chain_out);
    int F, b;
    bit lastc;
    F = flen(par);
    bus.prescale = PW'(P);
    if (!chain_in) begin
      bus.par_en = par;
      bus.rx_in  = 1'b0;
      cycle();
      tref = cyc;
    end
    for (int c = 0; c < F * P; c++) begin
      b     = c / P;
      lastc = (c % P == P - 1);
      bus.rx_in       = line_bit(b, c, err, par, d);
      bus.par_en      = ~par;
      bus.strt_glitch = (err == 1) && (b == 0) && lastc;
      bus.par_err     = (err == 2) && (b == 9) && lastc;
      bus.stp_err     = (err == 3) && (b == F - 1) && lastc;
      if (c == rst_at) begin
        rst_n     = 1'b0;
        bus.rx_in = 1'b1;
      end
      cycle();
      if (c == rst_at || bus.strt_glitch || bus.par_err || bus.stp_err) begin
        bus.strt_glitch = 1'b0; bus.par_err = 1'b0; bus.stp_err = 1'b0;
        bus.rx_in = 1'b1;
        return;
      end
    end
    bus.rx_in  = chain_out ? 1'b0 : 1'b1;
    bus.par_en = par;
    cycle();
    bus.rx_in  = 1'b1;
  endtask

  initial begin
    bus.rx_in = 1'b1; bus.prescale = PW'(8); bus.par_en = 1'b0;
    bus.strt_glitch = 1'b0; bus.par_err = 1'b0; bus.stp_err = 1'b0;
    reset_stats();
    rst_n = 1'b0;
    cycle();
    chk_on = 1;
    cycle();
    check("reset dat_samp_en", bus.dat_samp_en, 0);
    check("reset deser_en",    bus.deser_en,    0);
    check("reset data_valid",  bus.data_valid,  0);
    check("reset edge_cnt",    bus.edge_cnt,    0);
    check("reset bit_cnt",     bus.bit_cnt,     0);
    rst_n = 1'b1;
    repeat (2) cycle();

    // x8, no parity, 0xA5
    reset_stats();
    drive_frame(8, 0, 8'hA5, 0, -1, 0, 0);
    check("t1 dv count", dv_q.size(), 1);
    if (dv_q.size() > 0) check("t1 dv cycle", dv_q[0], 80);
    check("t1 deser first", ds_first, 8);
    check("t1 deser last",  ds_last,  80);
    repeat (3) cycle();

    // x8, parity, parity error on bit 9
    reset_stats();
    drive_frame(8, 1, 8'h5A, 2, -1, 0, 0);
    check("t2 idle at 80", bus.dat_samp_en, 0);
    check("t2 deser at 80", bus.deser_en, 0);
    check("t2 deser last", ds_last, 79);
    check("t2 no dv", dv_q.size(), 0);
    repeat (3) cycle();

    // short start pulse flagged as glitch
    reset_stats();
    drive_frame(8, 0, 8'hFF, 1, -1, 0, 0);
    check("t3 idle at 8", bus.dat_samp_en, 0);
    check("t3 deser never", ds_first, -1);
    check("t3 no dv", dv_q.size(), 0);
    repeat (3) cycle();

    // x16, parity, back-to-back frames
    reset_stats();
    drive_frame(16, 1, 8'h3C, 0, -1, 0, 1);
    drive_frame(16, 1, 8'hC3, 0, -1, 1, 0);
    check("t4 dv count", dv_q.size(), 2);
    if (dv_q.size() > 1) begin
      check("t4 dv1 cycle", dv_q[0], 176);
      check("t4 dv2 cycle", dv_q[1], 353);
    end
    repeat (3) cycle();

    // reset during DATA bit 5, then a clean restart
    reset_stats();
    bus.prescale = PW'(8);
    drive_frame(8, 0, 8'h00, 0, 40, 0, 0);
    check("t5 dat_samp_en", bus.dat_samp_en, 0);
    check("t5 deser_en",    bus.deser_en,    0);
    check("t5 strt_chk_en", bus.strt_chk_en, 0);
    check("t5 par_chk_en",  bus.par_chk_en,  0);
    check("t5 stp_chk_en",  bus.stp_chk_en,  0);
    check("t5 data_valid",  bus.data_valid,  0);
    check("t5 edge_cnt",    bus.edge_cnt,    0);
    check("t5 bit_cnt",     bus.bit_cnt,     0);
    rst_n = 1'b1;
    repeat (2) cycle();
    reset_stats();
    drive_frame(8, 0, 8'h81, 0, -1, 0, 0);
    check("t5 restart dv", dv_q.size(), 1);
    if (dv_q.size() > 0) check("t5 restart dv cycle", dv_q[0], 80);
    repeat (3) cycle();

    // stop error drops the frame
    reset_stats();
    drive_frame(8, 0, 8'h00, 3, -1, 0, 0);
    check("stop err no dv", dv_q.size(), 0);
    check("stop err idle", bus.dat_samp_en, 0);
    repeat (3) cycle();

    // x32, no parity: full edge range and stop-check window
    reset_stats();
    drive_frame(32, 0, 8'h96, 0, -1, 0, 0);
    check("t6 edge max", edge_max, 31);
    check("t6 stp first edge", stp_first, 18);
    check("t6 stp last edge",  stp_last,  31);
    check("t6 stp cycles",     stp_n,     14);
    check("t6 stp bit",        stp_bit,   9);
    if (dv_q.size() > 0) check("t6 dv cycle", dv_q[0], 320);
    else check("t6 dv count", dv_q.size(), 1);
    repeat (3) cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
